// File: rtl/ibex_pkg.sv
// Shared types for the register-file write arbiter: grant encoding and the
// queued external write request.
package ibex_pkg;

  typedef enum logic [1:0] {
    RF_WR_NONE = 2'd0,
    RF_WR_LSU  = 2'd1,
    RF_WR_ID   = 2'd2,
    RF_WR_EXT  = 2'd3
  } rf_wr_src_e;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_wr_req_t;

  localparam int unsigned            RfWaitCntW   = 4;
  localparam logic [RfWaitCntW-1:0] RfWaitCntMax = 4'd15;

  function automatic logic rf_wr_is_x0(input logic [4:0] waddr);
    return (waddr == 5'd0);
  endfunction

endpackage

// File: rtl/ibex_rf_wr_arbiter_chk.sv
// Protocol checks for the RF write arbiter: a single in-order writer per cycle
// and at most one outstanding external op per destination register.
module ibex_rf_wr_arbiter_chk (
  input logic        clk_i,
  input logic        rst_ni,
  input logic        lsu_we_i,
  input logic        id_we_i,
  input logic        ext_issue_i,
  input logic [4:0]  ext_issue_waddr_i,
  input logic [31:0] pending_i,
  input logic        pop_i,
  input logic [4:0]  pop_waddr_i
);

  a_single_writer: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(lsu_we_i && id_we_i));

  // Re-issuing to a register is fine only when its previous result retires now.
  a_single_outstanding: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (ext_issue_i && (ext_issue_waddr_i != 5'd0)) |->
      (!pending_i[ext_issue_waddr_i] || (pop_i && (pop_waddr_i == ext_issue_waddr_i))));

endmodule

// File: rtl/ibex_rf_wr_fifo.sv
// Two-entry FIFO of external write requests. push_i/pop_i arrive already
// qualified by the caller (no push when full, no pop when empty).
module ibex_rf_wr_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  rf_wr_req_t push_data_i,
  input  logic       pop_i,
  output rf_wr_req_t head_o,
  output logic       full_o,
  output logic       empty_o
);

  rf_wr_req_t mem_q [2];
  rf_wr_req_t mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] cnt_q, cnt_d;

  assign head_o  = mem_q[rd_ptr_q];
  assign full_o  = (cnt_q == 2'(Depth));
  assign empty_o = (cnt_q == 2'd0);

  // Next-state for storage, pointers and occupancy.
  always_comb begin
    mem_d = mem_q;
    if (push_i) begin
      mem_d[wr_ptr_q] = push_data_i;
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_i) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    cnt_d = cnt_q + {1'b0, push_i} - {1'b0, pop_i};
  end

  // State registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < 2; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: rtl/ibex_rf_wr_arbiter.sv
// Register-file write-port arbiter: LSU > ID/EX > queued external results.
// Define IBEX_RF_ARB_STATS_EN to add stall-cycle and external-write counters.
module ibex_rf_wr_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned MaxWait      = 4,
  parameter int unsigned ExtFifoDepth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        id_we_i,
  input  logic [4:0]  id_waddr_i,
  input  logic [31:0] id_wdata_i,
  input  logic        lsu_we_i,
  input  logic [4:0]  lsu_waddr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic        ext_issue_i,
  input  logic [4:0]  ext_issue_waddr_i,
  input  logic        ext_valid_i,
  output logic        ext_ready_o,
  input  logic [4:0]  ext_waddr_i,
  input  logic [31:0] ext_wdata_i,
  output logic        stall_id_o,
  output logic [31:0] pending_o,
  output logic        rf_we_o,
  output logic [4:0]  rf_waddr_o,
  output logic [31:0] rf_wdata_o
`ifdef IBEX_RF_ARB_STATS_EN
  ,
  output logic [31:0] stat_stall_cycles_o,
  output logic [31:0] stat_ext_writes_o
`endif
);

  rf_wr_src_e            grant_s;
  rf_wr_req_t            head_s;
  rf_wr_req_t            push_data_s;
  logic                  fifo_full_s, fifo_empty_s;
  logic                  push_s, pop_s;
  logic [RfWaitCntW-1:0] wait_cnt_q, wait_cnt_d;
  logic                  stall_q, stall_d;
  logic [31:0]           pending_q, pending_d;

  assign ext_ready_o = ~fifo_full_s;
  assign push_s      = ext_valid_i & ~fifo_full_s;
  assign pop_s       = (grant_s == RF_WR_EXT);
  assign push_data_s = '{waddr: ext_waddr_i, wdata: ext_wdata_i};
  assign stall_id_o  = stall_q;
  assign pending_o   = pending_q;

  ibex_rf_wr_fifo #(
    .Depth (ExtFifoDepth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .push_i      (push_s),
    .push_data_i (push_data_s),
    .pop_i       (pop_s),
    .head_o      (head_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s)
  );

  // Same-cycle grant and write-port mux; x0 targets drain without writing.
  always_comb begin
    if (lsu_we_i) begin
      grant_s = RF_WR_LSU;
    end else if (id_we_i) begin
      grant_s = RF_WR_ID;
    end else if (!fifo_empty_s) begin
      grant_s = RF_WR_EXT;
    end else begin
      grant_s = RF_WR_NONE;
    end
    case (grant_s)
      RF_WR_LSU: begin rf_waddr_o = lsu_waddr_i;  rf_wdata_o = lsu_wdata_i;  end
      RF_WR_ID:  begin rf_waddr_o = id_waddr_i;   rf_wdata_o = id_wdata_i;   end
      RF_WR_EXT: begin rf_waddr_o = head_s.waddr; rf_wdata_o = head_s.wdata; end
      default:   begin rf_waddr_o = 5'd0;         rf_wdata_o = 32'd0;        end
    endcase
    rf_we_o = (grant_s != RF_WR_NONE) && !rf_wr_is_x0(rf_waddr_o);
  end

  // Head wait counter, stall request and pending scoreboard next state.
  always_comb begin
    if (fifo_empty_s || pop_s) begin
      wait_cnt_d = '0;
    end else if (wait_cnt_q == RfWaitCntMax) begin
      wait_cnt_d = wait_cnt_q;
    end else begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
    stall_d = (wait_cnt_d >= 4'(MaxWait));

    pending_d = pending_q;
    if (pop_s && !rf_wr_is_x0(head_s.waddr)) begin
      pending_d[head_s.waddr] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    // Applied after the clear so a new issue wins over a retiring result.
    if (ext_issue_i && !rf_wr_is_x0(ext_issue_waddr_i)) begin
      pending_d[ext_issue_waddr_i] = 1'b1;
    end else begin
      pending_d = pending_d;
    end
  end

  // Control state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wait_cnt_q <= '0;
      stall_q    <= 1'b0;
      pending_q  <= 32'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      stall_q    <= stall_d;
      pending_q  <= pending_d;
    end
  end

`ifdef IBEX_RF_ARB_STATS_EN
  logic [31:0] stat_stall_cycles_q;
  logic [31:0] stat_ext_writes_q;

  assign stat_stall_cycles_o = stat_stall_cycles_q;
  assign stat_ext_writes_o   = stat_ext_writes_q;

  // Free-running statistics, wrapping at 2^32.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_stall_cycles_q <= 32'd0;
      stat_ext_writes_q   <= 32'd0;
    end else begin
      stat_stall_cycles_q <= stat_stall_cycles_q + {31'd0, stall_q};
      stat_ext_writes_q   <= stat_ext_writes_q +
                             {31'd0, (pop_s && !rf_wr_is_x0(head_s.waddr))};
    end
  end
`endif

  ibex_rf_wr_arbiter_chk u_chk (
    .clk_i             (clk_i),
    .rst_ni            (rst_ni),
    .lsu_we_i          (lsu_we_i),
    .id_we_i           (id_we_i),
    .ext_issue_i       (ext_issue_i),
    .ext_issue_waddr_i (ext_issue_waddr_i),
    .pending_i         (pending_q),
    .pop_i             (pop_s),
    .pop_waddr_i       (head_s.waddr)
  );

endmodule
